// File: rtl/comp_mem_sequencer.sv
// Compensation-weight store for the systolic array: LOAD captures per-column entries,
// ISSUE replays them over valid/ready. Optional macro COMP_ZERO_SKIP_EN drops zero weights on load.
module comp_mem_sequencer #(
    parameter int SIZE   = 8,
    parameter int SLOTS  = 3,
    parameter int COL_W  = $clog2(SIZE),
    parameter int SLOT_W = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [2:0]        in_weight,
    input  logic              in_col_end,
    input  logic              issue_start,
    input  logic              issue_ready,
    output logic              out_valid,
    output logic [2:0]        out_weight,
    output logic [COL_W-1:0]  out_col,
    output logic [SLOT_W-1:0] out_slot,
    output logic              busy,
    output logic              load_done,
    output logic              issue_done,
    output logic              overflow_err
);
    localparam int DEPTH  = SIZE * SLOTS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOTS);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, ISSUE} state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [SLOT_W-1:0] slot;
    logic [2:0]        mem   [DEPTH];
    logic [SLOT_W-1:0] count [SIZE];

    logic              wr_en, wr_ok, step, col_fin, last;
    logic [SLOT_W-1:0] slot_after, nxt_slot;
    logic [COL_W-1:0]  nxt_col;
    logic [ADDR_W-1:0] addr, nxt_addr;

    always_comb begin
`ifdef COMP_ZERO_SKIP_EN
        wr_en = in_valid && (in_weight != 3'd0);
`else
        wr_en = in_valid;
`endif
        wr_ok      = wr_en && (slot < SLOT_MAX);
        slot_after = wr_ok ? slot + SLOT_ONE : slot;
        addr       = ADDR_W'(col) * ADDR_W'(SLOTS) + ADDR_W'(slot);
        // An empty column (out_valid low) always steps; a valid entry steps only on handshake.
        step       = !out_valid || issue_ready;
        col_fin    = !out_valid || (slot + SLOT_ONE == count[col]);
        last       = step && col_fin && (col == COL_LAST);
        nxt_col    = col_fin ? col + COL_ONE : col;
        nxt_slot   = col_fin ? '0 : slot + SLOT_ONE;
        nxt_addr   = ADDR_W'(nxt_col) * ADDR_W'(SLOTS) + ADDR_W'(nxt_slot);
    end

    assign busy = (state == LOAD) || (state == ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            slot         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int unsigned i = 0; i < SIZE; i++) count[i] <= '0;
            out_valid    <= 1'b0;
            out_weight   <= '0;
            out_col      <= '0;
            out_slot     <= '0;
            load_done    <= 1'b0;
            issue_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            issue_done <= 1'b0;
            if (load_start && (state == IDLE || state == READY)) begin
                state        <= LOAD;
                col          <= '0;
                slot         <= '0;
                overflow_err <= 1'b0;
                for (int unsigned i = 0; i < SIZE; i++) count[i] <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_ok) mem[addr] <= in_weight;
                        else if (wr_en) overflow_err <= 1'b1;
                        if (in_col_end) begin
                            count[col] <= slot_after;
                            slot       <= '0;
                            if (col == COL_LAST) begin
                                col       <= '0;
                                state     <= READY;
                                load_done <= 1'b1;
                            end else begin
                                col <= col + COL_ONE;
                            end
                        end else begin
                            slot <= slot_after;
                        end
                    end
                    READY: begin
                        if (issue_start) begin
                            state      <= ISSUE;
                            col        <= '0;
                            slot       <= '0;
                            out_valid  <= (count[0] != '0);
                            out_weight <= mem[0];
                            out_col    <= '0;
                            out_slot   <= '0;
                        end
                    end
                    ISSUE: begin
                        if (step) begin
                            if (last) begin
                                out_valid  <= 1'b0;
                                issue_done <= 1'b1;
                                state      <= READY;
                                col        <= '0;
                                slot       <= '0;
                            end else begin
                                col        <= nxt_col;
                                slot       <= nxt_slot;
                                out_valid  <= (count[nxt_col] > nxt_slot);
                                out_weight <= mem[nxt_addr];
                                out_col    <= nxt_col;
                                out_slot   <= nxt_slot;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
